// File: rtl/hls_test1_hlsm_if.sv
// Start/Done job handshake bundle for hls_test1_hlsm.
// Busy is present only when HLSM_BUSY_EN is defined.
interface hls_test1_hlsm_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned Z_W    = 8
);
   logic              Start;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic [DATA_W-1:0] c;
   logic              Done;
   logic [Z_W-1:0]    z;
   logic [DATA_W-1:0] x;
`ifdef HLSM_BUSY_EN
   logic              Busy;
`endif

   modport master (
      output Start, a, b, c,
`ifdef HLSM_BUSY_EN
      input  Busy,
`endif
      input  Done, z, x
   );

   modport slave (
      input  Start, a, b, c,
`ifdef HLSM_BUSY_EN
      output Busy,
`endif
      output Done, z, x
   );
endinterface

// File: rtl/hls_test1_hlsm.sv
// Scheduled HLSM: z = max(a+b, a+c)[Z_W-1:0], x = a*c - (a+b), one job per MUL_LAT+4 cycles.
// Optional Busy output enabled by defining HLSM_BUSY_EN.
module hls_test1_hlsm #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned Z_W     = 8,
   parameter int unsigned MUL_LAT = 2
) (
   input logic             Clk,
   input logic             Rst,
   hls_test1_hlsm_if.slave bus
);

   typedef enum logic [2:0] {StWait, StAdd, StMul, StCmp, StFinal} state_e;

   localparam int unsigned    CntW    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(MUL_LAT - 1);

   state_e r_state, w_state_next;

   logic [DATA_W-1:0] r_a, r_b, r_c;
   logic [DATA_W-1:0] r_t1, r_t2, r_t3;
   logic [Z_W-1:0]    r_z;
   logic [DATA_W-1:0] r_x;
   logic [CntW-1:0]   r_cnt;

   logic [DATA_W-1:0] w_sum_ab, w_sum_ac, w_prod;
   logic              w_mul_last;

   assign w_sum_ab   = r_a + r_b;
   assign w_sum_ac   = r_a + r_c;
   assign w_prod     = r_a * r_c;
   assign w_mul_last = (r_cnt == CntLast);

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StWait:  if (bus.Start) w_state_next = StAdd;
         StAdd:   w_state_next = StMul;
         StMul:   if (w_mul_last) w_state_next = StCmp;
         StCmp:   w_state_next = StFinal;
         StFinal: w_state_next = StWait;
         default: w_state_next = StWait;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         r_state <= StWait;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Reset also discards any job in flight.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         r_a   <= '0;
         r_b   <= '0;
         r_c   <= '0;
         r_t1  <= '0;
         r_t2  <= '0;
         r_t3  <= '0;
         r_z   <= '0;
         r_x   <= '0;
         r_cnt <= '0;
      end else begin
         case (r_state)
            StWait: begin
               if (bus.Start) begin
                  r_a <= bus.a;
                  r_b <= bus.b;
                  r_c <= bus.c;
               end
            end
            StAdd: begin
               r_t1  <= w_sum_ab;
               r_t2  <= w_sum_ac;
               r_cnt <= '0;
            end
            StMul: begin
               r_cnt <= r_cnt + CntW'(1);
               if (w_mul_last) r_t3 <= w_prod;
            end
            StCmp: begin
               r_z <= (r_t1 > r_t2) ? r_t1[Z_W-1:0] : r_t2[Z_W-1:0];
               r_x <= r_t3 - r_t1;
            end
            default: ;
         endcase
      end
   end

   assign bus.Done = (r_state == StFinal);
   assign bus.z    = r_z;
   assign bus.x    = r_x;
`ifdef HLSM_BUSY_EN
   assign bus.Busy = (r_state != StWait);
`endif

endmodule
